// File: rtl/gpio_slice8_ctrl_pkg.sv
// Shared constants for the GPIO controller: register address map and address width.
package gpio_slice8_ctrl_pkg;

  localparam int unsigned RegAddrW = 3;

  localparam logic [RegAddrW-1:0] GPIO_DATA_OUT     = 3'd0;
  localparam logic [RegAddrW-1:0] GPIO_DIR_OE       = 3'd1;
  localparam logic [RegAddrW-1:0] GPIO_DATA_IN      = 3'd2;
  localparam logic [RegAddrW-1:0] GPIO_INTR_EN_RISE = 3'd3;
  localparam logic [RegAddrW-1:0] GPIO_INTR_EN_FALL = 3'd4;
  localparam logic [RegAddrW-1:0] GPIO_INTR_STATE   = 3'd5;
  localparam logic [RegAddrW-1:0] GPIO_FILTER_EN    = 3'd6;
  localparam logic [RegAddrW-1:0] GPIO_INPUT_EN     = 3'd7;

endpackage

// File: rtl/gpio_in_filter.sv
// One input bit: two-flop synchronizer followed by an optional hold-time glitch filter.
module gpio_in_filter #(
  parameter int unsigned FilterCycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  input  logic en_i,
  output logic filt_o,
  output logic filt_d_o
);

  localparam int unsigned CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  logic            sync1_q, sync2_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The counter saturates at CntMax by construction: reaching it always accepts and clears.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (!en_i) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o   = filt_q;
  assign filt_d_o = filt_d;

endmodule

// File: rtl/gpio_slice8_ctrl.sv
// GPIO controller for one pad slice: register file, filtered inputs, edge interrupts.
module gpio_slice8_ctrl
  import gpio_slice8_ctrl_pkg::*;
#(
  parameter int unsigned Width        = 8,
  parameter int unsigned FilterCycles = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                reg_we_i,
  input  logic                reg_re_i,
  input  logic [RegAddrW-1:0] reg_addr_i,
  input  logic [Width-1:0]    reg_wdata_i,
  output logic [Width-1:0]    reg_rdata_o,
  input  logic [Width-1:0]    pad_in_i,
  output logic [Width-1:0]    pad_out_o,
  output logic [Width-1:0]    pad_oe_o,
  output logic [Width-1:0]    pad_ie_o,
  output logic                intr_o
);

  logic [Width-1:0] data_out_q, dir_oe_q, intr_en_rise_q, intr_en_fall_q;
  logic [Width-1:0] intr_state_q, intr_state_d, filter_en_q, input_en_q;
  logic [Width-1:0] rdata_q, rdata_d;
  logic [Width-1:0] filt, filt_d, rise, fall, w1c_mask;

  for (genvar gi = 0; gi < Width; gi++) begin : g_in
    gpio_in_filter #(
      .FilterCycles(FilterCycles)
    ) u_filter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .in_i    (pad_in_i[gi]),
      .en_i    (filter_en_q[gi]),
      .filt_o  (filt[gi]),
      .filt_d_o(filt_d[gi])
    );
  end

  assign rise     = filt_d & ~filt;
  assign fall     = ~filt_d & filt;
  assign w1c_mask = (reg_we_i && reg_addr_i == GPIO_INTR_STATE) ? reg_wdata_i : '0;
  // Set is OR'd after the clear so a coincident edge keeps its bit.
  assign intr_state_d = (intr_state_q & ~w1c_mask)
                      | (rise & intr_en_rise_q) | (fall & intr_en_fall_q);

  always_comb begin
    rdata_d = rdata_q;
    if (reg_re_i) begin
      case (reg_addr_i)
        GPIO_DATA_OUT:     rdata_d = data_out_q;
        GPIO_DIR_OE:       rdata_d = dir_oe_q;
        GPIO_DATA_IN:      rdata_d = filt;
        GPIO_INTR_EN_RISE: rdata_d = intr_en_rise_q;
        GPIO_INTR_EN_FALL: rdata_d = intr_en_fall_q;
        GPIO_INTR_STATE:   rdata_d = intr_state_q;
        GPIO_FILTER_EN:    rdata_d = filter_en_q;
        GPIO_INPUT_EN:     rdata_d = input_en_q;
        default:           rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_out_q     <= '0;
      dir_oe_q       <= '0;
      intr_en_rise_q <= '0;
      intr_en_fall_q <= '0;
      intr_state_q   <= '0;
      filter_en_q    <= '0;
      input_en_q     <= '1;
      rdata_q        <= '0;
    end else begin
      intr_state_q <= intr_state_d;
      rdata_q      <= rdata_d;
      if (reg_we_i) begin
        case (reg_addr_i)
          GPIO_DATA_OUT:     data_out_q     <= reg_wdata_i;
          GPIO_DIR_OE:       dir_oe_q       <= reg_wdata_i;
          GPIO_INTR_EN_RISE: intr_en_rise_q <= reg_wdata_i;
          GPIO_INTR_EN_FALL: intr_en_fall_q <= reg_wdata_i;
          GPIO_FILTER_EN:    filter_en_q    <= reg_wdata_i;
          GPIO_INPUT_EN:     input_en_q     <= reg_wdata_i;
          default: ;
        endcase
      end
    end
  end

  assign pad_out_o   = data_out_q;
  assign pad_oe_o    = dir_oe_q;
  assign pad_ie_o    = input_en_q;
  assign reg_rdata_o = rdata_q;
  assign intr_o      = |intr_state_q;

endmodule

// File: tb/tb_gpio_slice8_ctrl.sv
// Directed bench for gpio_slice8_ctrl with hand-computed expectations.
module tb_gpio_slice8_ctrl;
  import gpio_slice8_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       reg_we_i = 1'b0;
  logic       reg_re_i = 1'b0;
  logic [2:0] reg_addr_i = '0;
  logic [7:0] reg_wdata_i = '0;
  logic [7:0] reg_rdata_o;
  logic [7:0] pad_in_i = '0;
  logic [7:0] pad_out_o, pad_oe_o, pad_ie_o;
  logic       intr_o;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_slice8_ctrl #(.Width(8), .FilterCycles(16)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .reg_we_i   (reg_we_i),
    .reg_re_i   (reg_re_i),
    .reg_addr_i (reg_addr_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_rdata_o(reg_rdata_o),
    .pad_in_i   (pad_in_i),
    .pad_out_o  (pad_out_o),
    .pad_oe_o   (pad_oe_o),
    .pad_ie_o   (pad_ie_o),
    .intr_o     (intr_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock edge; everything is driven and sampled 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
    $display("check %-18s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    reg_we_i = 1'b1; reg_addr_i = addr; reg_wdata_i = data;
    tick();
    reg_we_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] addr, output logic [7:0] data);
    reg_re_i = 1'b1; reg_addr_i = addr;
    tick();
    reg_re_i = 1'b0;
    data = reg_rdata_o;
  endtask

  logic [7:0] rv;
  logic [7:0] rst_exp [8];

  initial begin
    rst_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};

    // Reset defaults
    tick(3);
    rst_ni = 1'b1;
    chk("rst_intr", {7'd0, intr_o}, 8'h00);
    chk("rst_pad_ie", pad_ie_o, 8'hFF);
    chk("rst_pad_out", pad_out_o, 8'h00);
    chk("rst_pad_oe", pad_oe_o, 8'h00);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rv);
      chk($sformatf("rst_rd%0d", a), rv, rst_exp[a]);
    end

    // Output drive visible at the write edge
    wr(GPIO_DIR_OE, 8'h0F);
    chk("pad_oe", pad_oe_o, 8'h0F);
    wr(GPIO_DATA_OUT, 8'h05);
    chk("pad_out", pad_out_o, 8'h05);
    wr(GPIO_INPUT_EN, 8'h3C);
    chk("pad_ie", pad_ie_o, 8'h3C);
    rd(GPIO_DIR_OE, rv);
    chk("rd_dir_oe", rv, 8'h0F);

    // Simultaneous write and read returns the old value
    reg_we_i = 1'b1; reg_re_i = 1'b1; reg_addr_i = GPIO_DATA_OUT; reg_wdata_i = 8'hAA;
    tick();
    reg_we_i = 1'b0; reg_re_i = 1'b0;
    chk("wr_rd_old", reg_rdata_o, 8'h05);
    chk("wr_rd_pad", pad_out_o, 8'hAA);
    rd(GPIO_DATA_OUT, rv);
    chk("wr_rd_new", rv, 8'hAA);

    // Bypass rising interrupt on bit 7: visible after edge 3
    wr(GPIO_INTR_EN_RISE, 8'h80);
    pad_in_i = 8'h80;
    tick(2);
    chk("byp_intr_e2", {7'd0, intr_o}, 8'h00);
    tick();
    chk("byp_intr_e3", {7'd0, intr_o}, 8'h01);
    rd(GPIO_INTR_STATE, rv);
    chk("byp_state", rv, 8'h80);
    wr(GPIO_DATA_IN, 8'h00);
    rd(GPIO_DATA_IN, rv);
    chk("data_in_ro", rv, 8'h80);
    wr(GPIO_INTR_STATE, 8'h80);
    chk("w1c_intr", {7'd0, intr_o}, 8'h00);

    // Filter on bit 3: a 10-cycle pulse is dropped
    wr(GPIO_FILTER_EN, 8'h08);
    pad_in_i = 8'h88;
    tick(10);
    pad_in_i = 8'h80;
    tick(20);
    rd(GPIO_DATA_IN, rv);
    chk("glitch_drop", rv, 8'h80);

    // Steady level accepted at edge 18: read at edge 18 sees pre-edge value, edge 19 sees new
    pad_in_i = 8'h88;
    tick(17);
    rd(GPIO_DATA_IN, rv);
    chk("filt_e17", rv, 8'h80);
    rd(GPIO_DATA_IN, rv);
    chk("filt_e18", rv, 8'h88);
    chk("filt_no_intr", {7'd0, intr_o}, 8'h00);

    // Clearing FILTER_EN mid-count resumes bypass on the next edge
    pad_in_i = 8'h80;
    tick(8);
    wr(GPIO_FILTER_EN, 8'h00);
    tick();
    rd(GPIO_DATA_IN, rv);
    chk("filt_clear", rv, 8'h80);

    // Falling edge on bit 0 collides with a W1C: the set wins
    wr(GPIO_INTR_EN_FALL, 8'h01);
    pad_in_i = 8'h81;
    tick(5);
    chk("fall_pre", {7'd0, intr_o}, 8'h00);
    pad_in_i = 8'h80;
    tick(2);
    wr(GPIO_INTR_STATE, 8'h01);
    chk("collide_intr", {7'd0, intr_o}, 8'h01);
    rd(GPIO_INTR_STATE, rv);
    chk("collide_state", rv, 8'h01);
    wr(GPIO_INTR_STATE, 8'h01);
    chk("fall_cleared", {7'd0, intr_o}, 8'h00);

    // Reset during a filter count
    wr(GPIO_FILTER_EN, 8'h08);
    wr(GPIO_INTR_EN_RISE, 8'h08);
    pad_in_i = 8'h08;
    tick(10);
    rst_ni = 1'b0;
    tick();
    chk("rstmid_intr", {7'd0, intr_o}, 8'h00);
    chk("rstmid_ie", pad_ie_o, 8'hFF);
    chk("rstmid_out", pad_out_o, 8'h00);
    rst_ni = 1'b1;
    pad_in_i = 8'h00;
    rd(GPIO_DATA_IN, rv);
    chk("rstmid_filt", rv, 8'h00);
    rd(GPIO_FILTER_EN, rv);
    chk("rstmid_fen", rv, 8'h00);
    tick(20);
    chk("rstmid_quiet", {7'd0, intr_o}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_slice8_ctrl.md
# gpio_slice8_ctrl

GPIO controller that sits directly in front of `slice8_wrapper`.
- Drives the pad slice's `out_i`, `oe_i` and `ie_i`.
- Consumes the slice's `in_o`: a two-flop synchronizer, an optional per-bit glitch filter, then rising/falling edge detection.
- Exposes a small register port for software and one level interrupt output.

## Interface
Parameters:
- `Width`, 8, number of pads; matches one slice.
- `FilterCycles`, 16, number of consecutive cycles a changed input must hold before it is accepted. Legal range is ≥1.

Ports:
- `clk_i  in  1`  clock
- `rst_ni  in  1`  reset, synchronous, active-low
- `reg_we_i  in  1`  register write strobe
- `reg_re_i  in  1`  register read strobe
- `reg_addr_i  in  3`  register address
- `reg_wdata_i  in  Width`  write data
- `reg_rdata_o  out  Width`  read data, registered
- `pad_in_i  in  Width`  connects to slice `in_o`; asynchronous to `clk_i`
- `pad_out_o  out  Width`  connects to slice `out_i`
- `pad_oe_o  out  Width`  connects to slice `oe_i`
- `pad_ie_o  out  Width`  connects to slice `ie_i`
- `intr_o  out  1`  OR of all `INTR_STATE` bits

## Operation
Register map (all registers are Width bits):
- 0 `DATA_OUT`, read/write, reset 0. Drives `pad_out_o`.
- 1 `DIR_OE`, read/write, reset 0. Drives `pad_oe_o`.
- 2 `DATA_IN`, read-only, holds the filtered inputs. Writes are ignored.
- 3 `INTR_EN_RISE`, read/write, reset 0.
- 4 `INTR_EN_FALL`, read/write, reset 0.
- 5 `INTR_STATE`, write-1-to-clear, reset 0.
- 6 `FILTER_EN`, read/write, reset 0. When a bit is 0, that bit's filter is bypassed.
- 7 `INPUT_EN`, read/write, reset all ones. Drives `pad_ie_o`.

Input path, per bit:
- `sync1 <= pad_in_i`, then `sync2 <= sync1`. The filtered value is `filt`.
- Bypass (`FILTER_EN`=0): `filt <= sync2` every cycle, and the counter is held at 0.
- Filter (`FILTER_EN`=1):
  - If `sync2 == filt`, set `cnt <= 0`.
  - Otherwise, if `cnt == FilterCycles-1`, set `filt <= sync2` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt+1`.
- The counter is `$clog2(FilterCycles+1)` bits wide and never wraps.
- Any pulse shorter than FilterCycles cycles is discarded.

Edge detection and interrupts:
- Edges are computed from the next and current filtered values: `rise = filt_d & ~filt`, `fall = ~filt_d & filt`.
- `INTR_STATE[k]` is set when (`rise[k]` and `INTR_EN_RISE[k]`) or (`fall[k]` and `INTR_EN_FALL[k]`).
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.

Register access:
- An undefined address reads 0.
- Writes take effect on the same edge they are presented.
- If `reg_we_i` and `reg_re_i` are asserted together, the read returns the old value.

Reset values:
- All outputs are 0, except `pad_ie_o`, which is all ones.
- `sync1`, `sync2`, `filt` and `cnt` are all 0.

## Timing
- Input latency, measured from `pad_in_i` settling before edge 1:
  - Bypass: `filt` and `INTR_STATE` update at edge 3, so `intr_o` is high after edge 3.
  - Filter enabled: update at edge 2+FilterCycles (edge 18 at the default).
- Register write to pad: `pad_out_o`, `pad_oe_o` and `pad_ie_o` change at the write edge. There are no extra pipeline stages.
- Read: `reg_rdata_o` is valid the cycle after `reg_re_i` and holds its value until the next read.
- Changing a `FILTER_EN` bit mid-count:
  - Clearing it zeroes `cnt` and resumes bypass on the next edge.
  - Setting it starts counting from 0.
- Reset asserted mid-filter: all state returns to reset values at the next edge. No interrupt is raised by the reset itself.

## Structure
- Package `gpio_slice8_ctrl_pkg`:
  - register address localparams `GPIO_DATA_OUT` … `GPIO_INPUT_EN`;
  - the `RegAddrW = 3` constant.
- Sub-module `gpio_in_filter`: the single-bit synchronizer, filter and counter, with ports `clk_i`, `rst_ni`, `in_i`, `en_i`, `filt_o`, `filt_d_o`. It is instantiated `Width` times.
- The top level holds the register file, edge detection, interrupt logic and read mux.

## Test plan
- **Reset defaults:** after reset, read all 8 addresses → 0,0,0,0,0,0,0,0xFF; `intr_o`=0, `pad_ie_o`=0xFF.
- **Output drive:** write `DIR_OE`=0x0F, then `DATA_OUT`=0x05 → `pad_oe_o`=0x0F and `pad_out_o`=0x05 on the write edge.
- **Bypass rising interrupt:** set `INTR_EN_RISE`=0x80 and raise `pad_in_i[7]` → `intr_o`=1 after edge 3 and `INTR_STATE` reads 0x80. Write 0x80 to `INTR_STATE` → `intr_o`=0.
- **Filter glitch rejection:** `FILTER_EN`=0x08. A 10-cycle pulse on bit 3 leaves `DATA_IN[3]`=0. A 20-cycle high level gives `DATA_IN[3]`=1 at edge 18.
- **Falling edge with set/clear collision:** `INTR_EN_FALL`=0x01 and bit 0 previously high. Issue a W1C of bit 0 on the same cycle its fall is detected → `INTR_STATE[0]` stays 1.
- **Reset mid-filter:** assert `rst_ni`=0 during a count → `cnt`=0, `filt`=0 and `intr_o`=0 after the next edge.
